// File: rtl/pbl_pkg.sv
// Types and default widths shared between the register-stack sequencer and the decoder.
package pbl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SAVE = 2'd1,
    RD   = 2'd2,
    WR   = 2'd3
  } seq_state_t;

  localparam int DEF_VALUE_WIDTH    = 8;
  localparam int DEF_REGISTER_WIDTH = 3;
  localparam int DEF_STACK_DEPTH    = 64;
  localparam int DEF_REG_COUNT      = 8;

  // Stack pointer must be able to hold the value DEPTH itself (stack full).
  function automatic int sp_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_stack_sequencer_if.sv
// Decoder request/stall lines plus the register file's spare port, as seen by the sequencer.
interface reg_stack_sequencer_if import pbl_pkg::*; #(
  parameter int REGISTER_WIDTH = DEF_REGISTER_WIDTH,
  parameter int VALUE_WIDTH    = DEF_VALUE_WIDTH,
  parameter int SP_WIDTH       = sp_bits(DEF_STACK_DEPTH)
);
  logic                      push;
  logic                      pop;
  logic                      stall;
  logic                      busy;
  logic [REGISTER_WIDTH-1:0] rf_raddr;
  logic [VALUE_WIDTH-1:0]    rf_rdata;
  logic                      rf_we;
  logic [REGISTER_WIDTH-1:0] rf_waddr;
  logic [VALUE_WIDTH-1:0]    rf_wdata;
  logic [SP_WIDTH-1:0]       sp;
  logic                      overflow;
  logic                      underflow;

  modport master (
    input  push, pop, rf_rdata,
    output stall, busy, rf_raddr, rf_we, rf_waddr, rf_wdata, sp, overflow, underflow
  );

  modport slave (
    output push, pop, rf_rdata,
    input  stall, busy, rf_raddr, rf_we, rf_waddr, rf_wdata, sp, overflow, underflow
  );
endinterface

// File: rtl/data_stack_ram.sv
// Single-clock stack RAM: one write port, one registered read port, no reset on contents.
module data_stack_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/reg_stack_sequencer.sv
// Saves all registers to a private stack on push and restores them LIFO on pop,
// stalling the PC while the multi-cycle transfer runs.
module reg_stack_sequencer import pbl_pkg::*; #(
  parameter int REG_COUNT      = DEF_REG_COUNT,
  parameter int REGISTER_WIDTH = DEF_REGISTER_WIDTH,
  parameter int VALUE_WIDTH    = DEF_VALUE_WIDTH,
  parameter int STACK_DEPTH    = DEF_STACK_DEPTH,
  parameter int SP_WIDTH       = sp_bits(DEF_STACK_DEPTH)
) (
  input logic                   clk,
  input logic                   rst,
  reg_stack_sequencer_if.master bus
);
  localparam int AW = $clog2(STACK_DEPTH);
  localparam logic [REGISTER_WIDTH-1:0] IDX_LAST = REGISTER_WIDTH'(REG_COUNT - 1);
  localparam logic [SP_WIDTH:0]         DEPTH_W  = (SP_WIDTH + 1)'(STACK_DEPTH);
  localparam logic [SP_WIDTH:0]         COUNT_W  = (SP_WIDTH + 1)'(REG_COUNT);

  seq_state_t                state, state_nxt;
  logic [SP_WIDTH-1:0]       sp_q, sp_nxt;
  logic [REGISTER_WIDTH-1:0] idx_q, idx_nxt;
  logic                      ovf_q, ovf_nxt;
  logic                      udf_q, udf_nxt;

  logic                      stall;
  logic [REGISTER_WIDTH-1:0] rf_raddr, rf_waddr;
  logic                      rf_we;
  logic [VALUE_WIDTH-1:0]    rf_wdata;

  logic                      mem_we, mem_re;
  logic [AW-1:0]             mem_waddr, mem_raddr;
  logic [VALUE_WIDTH-1:0]    mem_rdata;

  data_stack_ram #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (VALUE_WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (bus.rf_rdata),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      sp_q  <= '0;
      idx_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      state <= state_nxt;
      sp_q  <= sp_nxt;
      idx_q <= idx_nxt;
      ovf_q <= ovf_nxt;
      udf_q <= udf_nxt;
    end
  end

  // Everything is gated by rst so an abandoned transfer neither writes the
  // RAM nor the register file, and outputs read zero while reset is held.
  always_comb begin
    state_nxt = state;
    sp_nxt    = sp_q;
    idx_nxt   = idx_q;
    ovf_nxt   = 1'b0;
    udf_nxt   = 1'b0;
    stall     = 1'b0;
    rf_raddr  = '0;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_waddr = AW'(sp_q);
    mem_raddr = AW'(sp_q - SP_WIDTH'(1));
    if (rst) begin
      unique case (state)
        IDLE: begin
          if (bus.push) begin
            if (({1'b0, sp_q} + COUNT_W) > DEPTH_W) begin
              ovf_nxt = 1'b1;
            end else begin
              stall     = 1'b1;
              idx_nxt   = '0;
              state_nxt = SAVE;
            end
          end else if (bus.pop) begin
            if (sp_q < SP_WIDTH'(REG_COUNT)) begin
              udf_nxt = 1'b1;
            end else begin
              stall     = 1'b1;
              idx_nxt   = IDX_LAST;
              state_nxt = RD;
            end
          end
        end
        SAVE: begin
          rf_raddr = idx_q;
          mem_we   = 1'b1;
          sp_nxt   = sp_q + SP_WIDTH'(1);
          idx_nxt  = idx_q + REGISTER_WIDTH'(1);
          // Drop stall in the last save so the PC moves past the held push.
          stall    = (idx_q != IDX_LAST);
          if (idx_q == IDX_LAST) state_nxt = IDLE;
        end
        RD: begin
          mem_re    = 1'b1;
          sp_nxt    = sp_q - SP_WIDTH'(1);
          stall     = 1'b1;
          state_nxt = WR;
        end
        WR: begin
          rf_we     = 1'b1;
          rf_waddr  = idx_q;
          rf_wdata  = mem_rdata;
          idx_nxt   = idx_q - REGISTER_WIDTH'(1);
          stall     = (idx_q != '0);
          state_nxt = (idx_q == '0) ? IDLE : RD;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.stall     = stall;
  assign bus.busy      = (state != IDLE);
  assign bus.rf_raddr  = rf_raddr;
  assign bus.rf_we     = rf_we;
  assign bus.rf_waddr  = rf_waddr;
  assign bus.rf_wdata  = rf_wdata;
  assign bus.sp        = sp_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;

endmodule

// File: tb/tb_reg_stack_sequencer.sv
// Scoreboard bench: a register-file model feeds the sequencer, expected restores are queued at pop time.
module tb_reg_stack_sequencer;
  localparam int RC  = 8;
  localparam int RW  = 3;
  localparam int VW  = 8;
  localparam int SD  = 64;
  localparam int SPW = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reg_stack_sequencer_if #(.REGISTER_WIDTH(RW), .VALUE_WIDTH(VW), .SP_WIDTH(SPW)) bus ();

  reg_stack_sequencer #(
    .REG_COUNT(RC), .REGISTER_WIDTH(RW), .VALUE_WIDTH(VW), .STACK_DEPTH(SD), .SP_WIDTH(SPW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // register file model: combinational read, bench preload or sequencer write
  logic [VW-1:0] rf      [RC];
  logic [VW-1:0] ld_vals [RC];
  logic          ld = 1'b0;
  assign bus.rf_rdata = rf[bus.rf_raddr];
  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < RC; i++) rf[i] <= ld_vals[i];
    end else if (bus.rf_we) begin
      rf[bus.rf_waddr] <= bus.rf_wdata;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  logic [VW-1:0]    mstack [$];
  logic [RW+VW-1:0] exp_wr [$];
  logic [VW-1:0]    rf_exp [RC];
  int               m_sp = 0;
  logic [RW+VW-1:0] mon_e;

  always @(negedge clk) begin
    if (rst && bus.rf_we) begin
      if (exp_wr.size() == 0) begin
        chk("unexp_we", 32'(bus.rf_we), 0);
      end else begin
        mon_e = exp_wr.pop_front();
        chk("wr_addr", 32'(bus.rf_waddr), 32'(mon_e[RW+VW-1:VW]));
        chk("wr_data", 32'(bus.rf_wdata), 32'(mon_e[VW-1:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_regs(input int base);
    for (int i = 0; i < RC; i++) begin
      ld_vals[i] = VW'(base + i);
      rf_exp[i]  = VW'(base + i);
    end
    ld = 1'b1;
    tick();
    ld = 1'b0;
  endtask

  task automatic do_push(input logic also_pop);
    int   n;
    logic acc;
    acc = (m_sp + RC <= SD);
    if (acc) begin
      for (int i = 0; i < RC; i++) mstack.push_back(rf_exp[i]);
      m_sp += RC;
    end
    bus.push = 1'b1;
    bus.pop  = also_pop;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!bus.stall) break;
      n++;
    end
    chk("push_stall_cycles", 32'(n), acc ? RC : 0);
    tick();
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    @(negedge clk);
    chk("push_busy_after", 32'(bus.busy), 0);
    chk("push_sp", 32'(bus.sp), 32'(m_sp));
    chk("push_overflow", 32'(bus.overflow), acc ? 0 : 1);
    chk("push_underflow", 32'(bus.underflow), 0);
    tick();
  endtask

  task automatic do_pop();
    int   n;
    logic acc;
    logic [VW-1:0] v;
    acc = (m_sp >= RC);
    if (acc) begin
      for (int i = RC - 1; i >= 0; i--) begin
        v = mstack.pop_back();
        exp_wr.push_back({RW'(i), v});
        rf_exp[i] = v;
      end
      m_sp -= RC;
    end
    bus.pop = 1'b1;
    n = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!bus.stall) break;
      n++;
    end
    chk("pop_stall_cycles", 32'(n), acc ? 2 * RC : 0);
    tick();
    bus.pop = 1'b0;
    @(negedge clk);
    chk("pop_busy_after", 32'(bus.busy), 0);
    chk("pop_sp", 32'(bus.sp), 32'(m_sp));
    chk("pop_underflow", 32'(bus.underflow), acc ? 0 : 1);
    chk("pop_pending_writes", 32'(exp_wr.size()), 0);
    for (int i = 0; i < RC; i++) chk("rf_restore", 32'(rf[i]), 32'(rf_exp[i]));
    tick();
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_sp"}, 32'(bus.sp), 0);
    chk({tag, "_stall"}, 32'(bus.stall), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_rf_we"}, 32'(bus.rf_we), 0);
    chk({tag, "_rf_raddr"}, 32'(bus.rf_raddr), 0);
    chk({tag, "_rf_waddr"}, 32'(bus.rf_waddr), 0);
    chk({tag, "_rf_wdata"}, 32'(bus.rf_wdata), 0);
    chk({tag, "_overflow"}, 32'(bus.overflow), 0);
    chk({tag, "_underflow"}, 32'(bus.underflow), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time %0t limit %0d", $time, 100000);
    $fatal(1);
  end

  initial begin
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    for (int i = 0; i < RC; i++) ld_vals[i] = '0;
    // reset
    rst = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk_idle_zero("reset");
    tick();
    rst = 1'b1;
    set_regs(0);

    // round trip
    set_regs('h10);
    do_push(1'b0);
    set_regs('hA0);
    do_pop();

    // nested
    set_regs('h20);
    do_push(1'b0);
    set_regs('h30);
    do_push(1'b0);
    set_regs('h00);
    do_pop();
    do_pop();

    // underflow, then held pop re-pulses
    do_pop();
    bus.pop = 1'b1;
    tick();
    tick();
    bus.pop = 1'b0;
    @(negedge clk);
    chk("udf_repulse", 32'(bus.underflow), 1);
    tick();
    @(negedge clk);
    chk("udf_clear", 32'(bus.underflow), 0);
    tick();

    // fill stack, then overflow
    for (int b = 0; b < SD / RC; b++) begin
      set_regs('h80 + b * RC);
      do_push(1'b0);
    end
    set_regs('hE0);
    do_push(1'b0);
    bus.push = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("ovf_repulse", 32'(bus.overflow), 1);
    chk("ovf_stall", 32'(bus.stall), 0);
    chk("ovf_sp", 32'(bus.sp), SD);
    bus.push = 1'b0;
    tick();
    for (int b = 0; b < SD / RC; b++) do_pop();

    // push wins over pop
    set_regs('h60);
    do_push(1'b1);
    do_pop();

    // reset in SAVE idx 3 abandons the push
    set_regs('h70);
    do_push(1'b0);
    set_regs('h40);
    bus.push = 1'b1;
    tick();
    tick();
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    bus.push = 1'b0;
    mstack.delete();
    m_sp = 0;
    @(negedge clk);
    chk_idle_zero("midrst");
    tick();
    set_regs('h90);
    do_push(1'b0);
    set_regs('h00);
    do_pop();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_stack_sequencer.md
# reg_stack_sequencer

Multi-cycle sequencer that serves the decoder's `push` and `pop` requests. On `push`, it saves every general-purpose register into a private data stack. On `pop`, it restores the registers in LIFO order. While a transfer runs it stalls the program counter, so the requesting instruction stays at `instr_addr` until the transfer completes. It sits beside the control module's return-address stack and owns the register file's spare read/write port during transfers.

## Interface
Parameters:
- `REG_COUNT`, 8: number of registers saved or restored per request.
- `REGISTER_WIDTH`, 3: register-address width; must satisfy 2^REGISTER_WIDTH >= REG_COUNT.
- `VALUE_WIDTH`, 8: register data width.
- `STACK_DEPTH`, 64: data-stack words; must be a multiple of REG_COUNT.
- `SP_WIDTH`, 7: stack-pointer width; must satisfy 2^SP_WIDTH > STACK_DEPTH.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `push` in 1: decoder save request (level, held while the instruction is current).
- `pop` in 1: decoder restore request (level).
- `stall` out 1: holds the PC; combinational from state and request.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `rf_raddr` out REGISTER_WIDTH: register-file read address.
- `rf_rdata` in VALUE_WIDTH: register-file read data, valid in the same cycle (combinational read).
- `rf_we` out 1: register-file write enable.
- `rf_waddr` out REGISTER_WIDTH: register-file write address.
- `rf_wdata` out VALUE_WIDTH: register-file write data.
- `sp` out SP_WIDTH: current stack pointer (words in use).
- `overflow` out 1: one-cycle pulse when a push is refused.
- `underflow` out 1: one-cycle pulse when a pop is refused.

## Operation
- States: IDLE, SAVE, RD, WR.
- Index counter `idx` is REGISTER_WIDTH wide. A single stack RAM has a write port and a registered (1-cycle) read port.
- **IDLE, push=1:**
  - If sp + REG_COUNT > STACK_DEPTH: assert `overflow` for one cycle, stay in IDLE, no stall.
  - Otherwise: set idx=0, go to SAVE.
- **IDLE, pop=1, push=0:**
  - If sp < REG_COUNT: assert `underflow` for one cycle, stay in IDLE.
  - Otherwise: set idx=REG_COUNT-1, go to RD.
- **Simultaneous push and pop:** push wins, pop is ignored.
- **SAVE:** rf_raddr=idx; mem[sp] <= rf_rdata; sp++; idx++. After idx==REG_COUNT-1 is handled, go to IDLE.
- **RD:** issue read at address sp-1; sp--; go to WR.
- **WR:** rf_we=1, rf_waddr=idx, rf_wdata=RAM read data; idx--. If idx was 0, go to IDLE; otherwise go to RD.
- **Ordering:** saves run ascending (r0 first), restores run descending, so each register regains its own value.
- **Request sampling:** requests are sampled only in IDLE; push/pop are ignored in every other state.
- **Width rules:**
  - Compare sp + REG_COUNT in SP_WIDTH+1 bits.
  - sp never wraps: refused requests leave it unchanged.
- RAM contents are not cleared by reset.

## Timing
- **Reset values** (rst=0 at a rising edge, in any state, including mid-transfer): state=IDLE, sp=0, idx=0. All outputs are 0: `stall`, `busy`, `rf_we`, `rf_raddr`, `rf_waddr`, `rf_wdata`, `overflow`, `underflow`. A partial push or pop is abandoned.
- **Push:**
  - Accept cycle plus REG_COUNT SAVE cycles, i.e. REG_COUNT+1 cycles total.
  - `stall`=1 from the accept cycle through SAVE idx==REG_COUNT-2.
  - `stall`=0 in the final SAVE cycle, so the PC advances on the same edge the FSM returns to IDLE. The held push is therefore never re-sampled.
- **Pop:**
  - Accept cycle plus 2*REG_COUNT cycles.
  - `stall`=0 only in the final WR cycle (idx==0).
- **Stall source:** in IDLE, `stall` = accepted request (combinational, no refusal). In SAVE/RD/WR, it is the registered state decode described above.
- **Busy:** `busy`=1 in SAVE, RD and WR.
- **Refusal pulses:** `overflow`/`underflow` are registered and appear one cycle after the refused request. They re-pulse every cycle the refused request stays high.

## Structure
- Shared package `pbl_pkg`: state enum `seq_state_t` {IDLE, SAVE, RD, WR} and defaults for VALUE_WIDTH, REGISTER_WIDTH and STACK_DEPTH, shared with the decoder.
- Sub-module `data_stack_ram`: single-clock RAM with one write port and a registered read port, parameterised by depth and width. All other logic is the FSM in the top module.

## Test plan
- **Round trip:** r0..r7 = 8'h10..8'h17, push held 1 -> mem[0..7] = 10..17, sp=8, stall high 8 cycles, returns to IDLE on cycle 9. Then clobber the registers, pop -> r0..r7 = 10..17 again, sp=0, stall high 16 cycles.
- **Nested:** push (A values), push (B values), pop, pop -> B restored first, then A; final sp=0.
- **Overflow:** with sp=64, push -> overflow pulse one cycle later, stall=0, sp=64, no RAM write. Underflow: with sp=0, pop -> underflow pulse, rf_we never asserted.
- **Priority:** push=pop=1 in IDLE with sp=0 -> save executes, sp=8, no underflow.
- **Reset mid-transfer:** rst=0 during SAVE idx=3 -> next cycle state=IDLE, sp=0, stall=0, all outputs 0. A new push afterwards works normally.
